// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX paths.
package uart_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/parity_calc.sv
// Parity generator: XOR-reduce of the data word, inverted for odd parity.
module parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_typ_i,
  output logic             par_bit_o
);

  // Even parity yields the reduction itself; odd parity flips it.
  always_comb begin
    par_bit_o = (^data_i) ^ (par_typ_i == PAR_ODD);
  end

endmodule : parity_calc

// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             par_bit_c;
  logic             load_c;

  // PAR_TYP is folded into the parity bit at load time, so only the result is held.
  parity_calc #(
    .WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data_i    (P_DATA),
    .par_typ_i (PAR_TYP),
    .par_bit_o (par_bit_c)
  );

  // A strobe is only honoured in IDLE; anything else is a tolerated protocol violation.
  always_comb begin
    load_c = (state_q == IDLE) && Data_Valid;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Data_Valid) state_d = START;
      START:   state_d = DATA;
      DATA:    if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit counter and per-frame parity settings.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (load_c) begin
      par_en_d  = PAR_EN;
      par_bit_d = par_bit_c;
    end
    if (state_q == START) begin
      bit_cnt_d = '0;
    end else if (state_q == DATA) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Line mux and status decode straight from the state.
  always_comb begin
    TX_OUT = 1'b1;
    ser_en = 1'b0;
    busy   = 1'b1;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      START:   TX_OUT = 1'b0;
      DATA: begin
        TX_OUT = ser_data;
        ser_en = 1'b1;
      end
      PARITY:  TX_OUT = par_bit_q;
      STOP:    TX_OUT = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule : uart_tx_fsm

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame sequencer for the UART transmit path. It accepts a byte-load strobe, drives the enable of the TX serializer that shifts the data bits, and computes the parity bit. It produces the serial line by multiplexing start, data, parity and stop bits. It sits between the upstream register/data-sync stage and the TX pin. CLK is the UART TX bit clock, so one line bit lasts exactly one CLK cycle.

## Interface
Parameters:
- DATA_WIDTH, 8, number of data bits per frame; also the width of P_DATA.

Ports:
- CLK  in  1  TX bit clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- P_DATA  in  DATA_WIDTH  parallel byte. Used only for the parity calculation; the serializer loads the same bus.
- Data_Valid  in  1  single-cycle load strobe.
- PAR_EN  in  1  1 = a parity bit follows the data bits. Sampled with Data_Valid.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity. Sampled with Data_Valid.
- ser_data  in  1  current data bit presented by the serializer.
- ser_en  out  1  advance enable to the serializer.
- TX_OUT  out  1  serial line, idle high.
- busy  out  1  a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state is held in a register.
- IDLE:
  - On Data_Valid=1, latch PAR_EN, PAR_TYP and par_bit, then go to START.
  - par_bit = (XOR-reduce of P_DATA) XOR PAR_TYP.
- START: lasts one cycle, then goes to DATA. Clear bit_cnt.
- DATA: lasts DATA_WIDTH cycles.
  - bit_cnt increments from 0 to DATA_WIDTH-1.
  - When bit_cnt = DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, otherwise go to STOP.
- PARITY: lasts one cycle, then goes to STOP.
- STOP: lasts one cycle, then goes to IDLE.
- TX_OUT is a combinational decode of the state:
  - IDLE → 1
  - START → 0
  - DATA → ser_data
  - PARITY → latched par_bit
  - STOP → 1
- ser_en = 1 only in DATA.
- busy = 1 in every state except IDLE.
- bit_cnt width is clog2(DATA_WIDTH). It is never compared beyond DATA_WIDTH-1.
- Data_Valid is ignored in every state except IDLE. This includes STOP. The latched parity settings and par_bit are not disturbed.
- Upstream contract: Data_Valid is pulsed only while busy=0. The serializer reloads on any Data_Valid, so a strobe while busy is a protocol violation. This block tolerates it without changing state.
- Changes to PAR_EN, PAR_TYP or P_DATA after the load cycle have no effect on the current frame.

## Timing
- Reset (RST=1, asynchronous, immediate, including mid-frame):
  - state = IDLE, bit_cnt = 0, latched parity fields = 0.
  - TX_OUT = 1, busy = 0, ser_en = 0.
  - The block leaves reset on the first edge after RST falls.
- Edge E0 samples Data_Valid=1 in IDLE. The cycle after E0 is START: TX_OUT=0 and busy=1.
- The next DATA_WIDTH cycles are DATA. TX_OUT shows data bit 0 first (LSB first) through bit DATA_WIDTH-1.
- Then one PARITY cycle (only if enabled), then one STOP cycle.
- busy is high for 1+DATA_WIDTH+1 cycles without parity, or 1+DATA_WIDTH+2 cycles with parity. That is 10 or 11 cycles at the default DATA_WIDTH.
- The earliest next accepted Data_Valid is in the first IDLE cycle after STOP. Back-to-back frames therefore have at least one idle-high bit between them.
- Latency from the Data_Valid edge to the falling start bit is one cycle.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the default DATA_WIDTH;
  - the parity-type constants PAR_EVEN=0 and PAR_ODD=1.
  - The RX side reuses these.
- One sub-module is natural: parity_calc. It is a combinational XOR-reduce of P_DATA plus PAR_TYP, producing par_bit, and is shared with the RX parity checker.
- The FSM, bit counter and output mux stay in uart_tx_fsm.
- The testbench pairs this block with a behavioural serializer model that presents bit 0 after the load and advances on ser_en.

## Test plan
- RST pulsed high during DATA bit 3 → TX_OUT=1, busy=0, ser_en=0 within the same cycle. No further bits after release until a new Data_Valid.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; busy high for exactly 11 cycles.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 → parity cycle TX_OUT=1.
- P_DATA=0x0F, PAR_EN=0 → sequence 0,1,1,1,1,0,0,0,0,1; busy high for 10 cycles; no PARITY state.
- Data_Valid re-pulsed during DATA bit 4, with PAR_TYP flipped → state, bit_cnt and the parity bit of the current frame are unchanged; busy timing is unchanged.
- Second Data_Valid on the first IDLE cycle after STOP → exactly one idle-high cycle between the two frames; the second frame is correct.
